// File: rtl/d5m_axis_packer.sv
// d5m_axis_packer: D5M pixel port to AXI4-Stream bridge.
// Packs PIXELS_PER_BEAT pixels per beat (first pixel in the LSBs), flags
// start-of-frame on tuser and end-of-line on tlast, and buffers beats in a
// FIFO_DEPTH-entry FIFO with sticky overflow and a completed-frame counter.
// Optional line/frame geometry checking is built when the macro
// D5M_AXIS_PACKER_GEOM_CHECK_EN is defined; otherwise width_err/height_err
// are tied low.
module d5m_axis_packer #(
    parameter int unsigned DATA_WIDTH      = 24,
    parameter int unsigned PIXELS_PER_BEAT = 2,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned IMG_WIDTH       = 1920,
    parameter int unsigned IMG_HEIGHT      = 1080
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ifval,
    input  logic                                  ilval,
    input  logic [DATA_WIDTH-1:0]                 idata,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tvalid,
    output logic [DATA_WIDTH*PIXELS_PER_BEAT-1:0] m_axis_tdata,
    output logic [PIXELS_PER_BEAT-1:0]            m_axis_tkeep,
    output logic                                  m_axis_tuser,
    output logic                                  m_axis_tlast,
    output logic                                  overflow,
    output logic [15:0]                           frame_count,
    output logic                                  width_err,
    output logic                                  height_err
);

    localparam int unsigned BEAT_W  = DATA_WIDTH * PIXELS_PER_BEAT;
    localparam int unsigned CNT_W   = $clog2(PIXELS_PER_BEAT + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = AW + 1;
    localparam int unsigned ENTRY_W = BEAT_W + PIXELS_PER_BEAT + 2;
    localparam int unsigned FC_W    = 16;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  ifval_prev_q, ilval_prev_q;
    logic [BEAT_W-1:0]     asm_data_q, asm_data_d;
    logic [CNT_W-1:0]      asm_cnt_q, asm_cnt_d;
    logic [BEAT_W-1:0]     hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  sof_pending_q, sof_pending_d;
    logic                  overflow_q, overflow_d;
    logic [FC_W-1:0]       frame_count_q, frame_count_d;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FCNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [ENTRY_W-1:0]    out_entry_q, out_entry_d;

    logic                  if_rise, if_fall, il_fall;
    logic                  frame_start, frame_end, line_end, accept;
    logic                  push, pop, fifo_full, wr_en;
    logic [BEAT_W-1:0]     push_data;
    logic [PIXELS_PER_BEAT-1:0] push_keep;
    logic                  push_user, push_last;
    logic [ENTRY_W-1:0]    push_entry;

    // Frame/line edge detection and event decode.
    always_comb begin
        if_rise     = ifval & ~ifval_prev_q;
        if_fall     = ~ifval & ifval_prev_q;
        il_fall     = ~ilval & ilval_prev_q;
        frame_start = if_rise && (state_q != ACTIVE);
        frame_end   = if_fall && (state_q != WAIT_SOF);
        line_end    = (state_q == ACTIVE) && (il_fall || if_fall);
        accept      = (state_q == ACTIVE) && !line_end && ifval && ilval;
    end

    // Packing FSM: next state, assembly/hold registers and push requests.
    always_comb begin
        state_d       = state_q;
        asm_data_d    = asm_data_q;
        asm_cnt_d     = asm_cnt_q;
        hold_data_d   = hold_data_q;
        hold_valid_d  = hold_valid_q;
        sof_pending_d = sof_pending_q;
        overflow_d    = overflow_q;
        frame_count_d = frame_count_q;
        push          = 1'b0;
        push_data     = '0;
        push_keep     = '0;
        push_last     = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                if (frame_start) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (line_end) begin
                    if (hold_valid_q) begin
                        push         = 1'b1;
                        push_data    = hold_data_q;
                        push_keep    = '1;
                        push_last    = (asm_cnt_q == '0);
                        hold_valid_d = 1'b0;
                    end
                    if (asm_cnt_q != '0) begin
                        state_d = FLUSH;
                    end else if (if_fall) begin
                        state_d = WAIT_SOF;
                    end
                end else if (accept) begin
                    if (hold_valid_q) begin
                        push         = 1'b1;
                        push_data    = hold_data_q;
                        push_keep    = '1;
                        hold_valid_d = 1'b0;
                    end
                    for (int i = 0; i < int'(PIXELS_PER_BEAT); i++) begin
                        if (asm_cnt_q == CNT_W'(i)) begin
                            asm_data_d[i*DATA_WIDTH +: DATA_WIDTH] = idata;
                        end
                    end
                    if (asm_cnt_q == CNT_W'(PIXELS_PER_BEAT - 1)) begin
                        hold_data_d  = asm_data_d;
                        hold_valid_d = 1'b1;
                        asm_data_d   = '0;
                        asm_cnt_d    = '0;
                    end else begin
                        asm_cnt_d = asm_cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                push      = 1'b1;
                push_data = asm_data_q;
                push_last = 1'b1;
                for (int i = 0; i < int'(PIXELS_PER_BEAT); i++) begin
                    push_keep[i] = (CNT_W'(i) < asm_cnt_q);
                end
                asm_data_d = '0;
                asm_cnt_d  = '0;
                state_d    = ifval ? ACTIVE : WAIT_SOF;
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase

        push_user = sof_pending_q;
        if (push) begin
            sof_pending_d = 1'b0;
        end
        if (frame_start) begin
            sof_pending_d = 1'b1;
        end

        if (frame_end) begin
            frame_count_d = frame_count_q + FC_W'(1);
        end

        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (frame_start) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers and the registered output stage (one cycle behind writes).
    always_comb begin
        pop         = out_valid_q && m_axis_tready;
        fifo_full   = (fifo_cnt_q == FCNT_W'(FIFO_DEPTH));
        wr_en       = push && (!fifo_full || pop);
        push_entry  = {push_user, push_last, push_keep, push_data};
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(wr_en);
        fifo_cnt_d  = fifo_cnt_q + FCNT_W'(wr_en) - FCNT_W'(pop);
        out_valid_d = ((fifo_cnt_q - FCNT_W'(pop)) != '0);
        out_entry_d = out_valid_d ? mem_q[rd_ptr_d] : '0;
    end

    // Beat storage; contents are only observed through the valid-gated output.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // State registers. ifval history resets high so a frame in progress at
    // reset release is not mistaken for a new start of frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            ifval_prev_q  <= 1'b1;
            ilval_prev_q  <= 1'b0;
            asm_data_q    <= '0;
            asm_cnt_q     <= '0;
            hold_data_q   <= '0;
            hold_valid_q  <= 1'b0;
            sof_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_entry_q   <= '0;
        end else begin
            state_q       <= state_d;
            ifval_prev_q  <= ifval;
            ilval_prev_q  <= ilval;
            asm_data_q    <= asm_data_d;
            asm_cnt_q     <= asm_cnt_d;
            hold_data_q   <= hold_data_d;
            hold_valid_q  <= hold_valid_d;
            sof_pending_q <= sof_pending_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            out_valid_q   <= out_valid_d;
            out_entry_q   <= out_entry_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_entry_q[BEAT_W-1:0];
    assign m_axis_tkeep  = out_entry_q[BEAT_W +: PIXELS_PER_BEAT];
    assign m_axis_tlast  = out_entry_q[ENTRY_W-2];
    assign m_axis_tuser  = out_entry_q[ENTRY_W-1];
    assign overflow      = overflow_q;
    assign frame_count   = frame_count_q;

`ifdef D5M_AXIS_PACKER_GEOM_CHECK_EN
    localparam int unsigned GEOM_W = 16;

    logic [GEOM_W-1:0] line_px_q, line_px_d;
    logic [GEOM_W-1:0] line_cnt_q, line_cnt_d;
    logic              width_err_q, width_err_d;
    logic              height_err_q, height_err_d;

    // Per-line pixel count and per-frame line count against the expected geometry.
    always_comb begin
        line_px_d    = line_px_q;
        line_cnt_d   = line_cnt_q;
        width_err_d  = width_err_q;
        height_err_d = height_err_q;

        if (line_end) begin
            if (line_px_q != '0) begin
                if (line_px_q != GEOM_W'(IMG_WIDTH)) begin
                    width_err_d = 1'b1;
                end
                line_cnt_d = line_cnt_q + GEOM_W'(1);
            end
            line_px_d = '0;
        end else if (accept) begin
            line_px_d = line_px_q + GEOM_W'(1);
        end

        if (frame_end) begin
            if (line_cnt_d != GEOM_W'(IMG_HEIGHT)) begin
                height_err_d = 1'b1;
            end
            line_cnt_d = '0;
            line_px_d  = '0;
        end

        if (frame_start) begin
            line_px_d    = '0;
            line_cnt_d   = '0;
            width_err_d  = 1'b0;
            height_err_d = 1'b0;
        end
    end

    // Geometry counter and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_px_q    <= '0;
            line_cnt_q   <= '0;
            width_err_q  <= 1'b0;
            height_err_q <= 1'b0;
        end else begin
            line_px_q    <= line_px_d;
            line_cnt_q   <= line_cnt_d;
            width_err_q  <= width_err_d;
            height_err_q <= height_err_d;
        end
    end

    assign width_err  = width_err_q;
    assign height_err = height_err_q;
`else
    logic unused_geom_params;

    assign unused_geom_params = (IMG_WIDTH != 0) ^ (IMG_HEIGHT != 0);
    assign width_err          = 1'b0;
    assign height_err         = 1'b0;
`endif

endmodule

// File: tb/tb_d5m_axis_packer.sv
// Directed self-checking bench for d5m_axis_packer (2 pixels/beat, 4-beat FIFO,
// 8x4 nominal geometry).
module tb_d5m_axis_packer;

    localparam int unsigned DW    = 24;
    localparam int unsigned PPB   = 2;
    localparam int unsigned BW    = DW * PPB;
    localparam int unsigned DEPTH = 4;
`ifdef D5M_AXIS_PACKER_GEOM_CHECK_EN
    localparam logic GEOM = 1'b1;
`else
    localparam logic GEOM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ifval, ilval;
    logic [DW-1:0] idata;
    logic          tready;
    logic          tvalid, tuser, tlast;
    logic [BW-1:0] tdata;
    logic [PPB-1:0] tkeep;
    logic          overflow, width_err, height_err;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW+PPB+1:0] rx_q[$];
    logic [BW+PPB+1:0] exp_q[$];

    always #5 clk = ~clk;

    d5m_axis_packer #(
        .DATA_WIDTH(DW), .PIXELS_PER_BEAT(PPB), .FIFO_DEPTH(DEPTH),
        .IMG_WIDTH(8), .IMG_HEIGHT(4)
    ) dut (
        .clk(clk), .reset(reset), .ifval(ifval), .ilval(ilval), .idata(idata),
        .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .overflow(overflow), .frame_count(frame_count),
        .width_err(width_err), .height_err(height_err)
    );

    // Capture accepted beats half a cycle before the handshake edge.
    always @(negedge clk) begin
        if (!reset && tvalid && tready) rx_q.push_back({tuser, tlast, tkeep, tdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] pix(input int f, input int l, input int p);
        logic [7:0] a, b, c;
        a = f[7:0];
        b = l[7:0];
        c = p[7:0];
        return {a, b, c};
    endfunction

    // Drive one frame and append its expected beats to exp_q.
    task automatic send_frame(input int nl, input int np, input int f);
        int nb;
        logic [BW-1:0] d;
        logic [PPB-1:0] k;
        logic first;
        first = 1'b1;
        nb = (np + int'(PPB) - 1) / int'(PPB);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb; b++) begin
                d = '0;
                k = '0;
                for (int s = 0; s < int'(PPB); s++) begin
                    if (b * int'(PPB) + s < np) begin
                        d[s*DW +: DW] = pix(f, l, b * int'(PPB) + s);
                        k[s] = 1'b1;
                    end
                end
                exp_q.push_back({first, logic'(b == nb - 1), k, d});
                first = 1'b0;
            end
        end
        ifval = 1'b1;
        ilval = 1'b0;
        tick(2);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                ilval = 1'b1;
                idata = pix(f, l, p);
                tick();
            end
            ilval = 1'b0;
            idata = '0;
            tick(3);
        end
        ifval = 1'b0;
        tick(3);
    endtask

    // Wait (bounded) for the expected beats, then compare them in order.
    task automatic drain_and_compare(input string name);
        int budget;
        budget = 200;
        while (rx_q.size() < exp_q.size() && budget > 0) begin
            tick();
            budget--;
        end
        tick(8);
        check({name, "_beat_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_beat%0d", name, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        ifval  = 1'b0;
        ilval  = 1'b0;
        idata  = '0;
        tready = 1'b1;
        tick(2);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_geom_err", 64'({width_err, height_err}), 64'd0);
        reset = 1'b0;
        tick(2);

        // Baseline 8x4 frame.
        send_frame(4, 8, 1);
        drain_and_compare("base");
        check("base_frame_count", 64'(frame_count), 64'd1);
        check("base_overflow", 64'(overflow), 64'd0);
        check("base_geom_err", 64'({width_err, height_err}), 64'd0);

        // One 7-pixel line: final partial beat.
        send_frame(1, 7, 2);
        drain_and_compare("partial");
        check("partial_frame_count", 64'(frame_count), 64'd2);
        check("partial_width_err", 64'(width_err), 64'(GEOM));
        check("partial_height_err", 64'(height_err), 64'(GEOM));

        // Geometry: 9-pixel line, then a 3-line frame.
        send_frame(1, 9, 3);
        drain_and_compare("wide");
        check("wide_width_err", 64'(width_err), 64'(GEOM));
        send_frame(3, 8, 4);
        drain_and_compare("short");
        check("short_width_err", 64'(width_err), 64'd0);
        check("short_height_err", 64'(height_err), 64'(GEOM));
        check("short_frame_count", 64'(frame_count), 64'd4);

        // Backpressure: 16-beat frame into a 4-beat FIFO with tready low.
        tready = 1'b0;
        send_frame(4, 8, 5);
        exp_q = exp_q[0:3];
        tick(5);
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_geom_err", 64'({width_err, height_err}), 64'd0);
        check("bp_no_pop", 64'(rx_q.size()), 64'd0);
        check("bp_hold_tvalid", 64'(tvalid), 64'd1);
        check("bp_hold_head", 64'({tuser, tlast, tkeep, tdata}), 64'(exp_q[0]));
        tready = 1'b1;
        drain_and_compare("bp");
        check("bp_frame_count", 64'(frame_count), 64'd5);
        check("bp_overflow_kept", 64'(overflow), 64'd1);
        ifval = 1'b1;
        tick(2);
        check("bp_overflow_clear", 64'(overflow), 64'd0);
        ifval = 1'b0;
        tick(3);
        drain_and_compare("empty");
        check("empty_frame_count", 64'(frame_count), 64'd6);

        // Reset mid-frame, released with ifval still high.
        ifval = 1'b1;
        tick(2);
        for (int p = 0; p < 5; p++) begin
            ilval = 1'b1;
            idata = pix(6, 0, p);
            tick();
        end
        reset = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_tdata", 64'({tuser, tlast, tkeep, tdata}), 64'd0);
        check("mid_rst_frame_count", 64'(frame_count), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        tick(2);
        rx_q.delete();
        reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 8; p++) begin
                ilval = 1'b1;
                idata = pix(7, l, p);
                tick();
            end
            ilval = 1'b0;
            tick(3);
        end
        ifval = 1'b0;
        tick(3);
        drain_and_compare("stale");
        check("stale_frame_count", 64'(frame_count), 64'd0);
        send_frame(2, 8, 8);
        drain_and_compare("post_rst");
        check("post_rst_frame_count", 64'(frame_count), 64'd1);

        // Frame counter wrap.
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tick();
        check("wrap_preload", 64'(frame_count), 64'hFFFF);
        ifval = 1'b1;
        tick(2);
        ifval = 1'b0;
        tick(2);
        check("wrap_frame_count", 64'(frame_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
